// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared fetch-stage constants, FSM encodings and IF/ID mux selects.
package if_fetch_unit_pkg;
    localparam int PC_W = 16;
    localparam int IR_W = 19;
    localparam logic [IR_W-1:0] NOP_INSTR = '0;
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_FETCH = 2'd0;
    localparam fetch_state_t ST_HOLD  = 2'd1;
    localparam fetch_state_t ST_DROP  = 2'd2;
    localparam fetch_state_t ST_FAULT = 2'd3;
    typedef enum logic [1:0] {
        MUX_IF_PM_NORMAL = 2'b00,
        MUX_IF_PM_FLUSH  = 2'b01,
        MUX_IF_PM_FREEZE = 2'b10
    } mux_if_pm_t;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: program-memory req/ack bus between the fetch stage and instruction memory.
interface if_fetch_unit_if #(
    parameter int PC_W = if_fetch_unit_pkg::PC_W,
    parameter int IR_W = if_fetch_unit_pkg::IR_W
) ();
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [IR_W-1:0] imem_rdata;
    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, fetches over req/ack, honours stall/redirect and never presents stale instructions.
module if_fetch_unit #(
    parameter int              PC_W          = if_fetch_unit_pkg::PC_W,
    parameter int              IR_W          = if_fetch_unit_pkg::IR_W,
    parameter logic [PC_W-1:0] RESET_PC      = '0,
    parameter int              FETCH_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect_en,
    input  logic [PC_W-1:0]       redirect_pc,
    if_fetch_unit_if.master       imem,
    output logic [PC_W-1:0]       PC_Out,
    output logic [IR_W-1:0]       IR_IF,
    output logic                  if_valid,
    output logic                  fetch_fault
);
    import if_fetch_unit_pkg::*;
    localparam int TW = $clog2(FETCH_TIMEOUT + 1);
    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc, r_req_addr, r_sk_pc, r_pc_out;
    logic [IR_W-1:0] r_sk_ir, r_ir;
    logic            r_valid, r_fault;
    logic [TW-1:0]   r_tcnt;
    logic            w_req, w_ack, w_wait, w_timeout;
    assign w_req     = (r_state == ST_FETCH) || (r_state == ST_DROP);
    assign w_ack     = w_req && imem.imem_ack;
    assign w_wait    = w_req && !imem.imem_ack;
    assign w_timeout = w_wait && (r_tcnt == TW'(FETCH_TIMEOUT - 1));
    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_req_addr;
    assign PC_Out      = r_pc_out;
    assign IR_IF       = r_ir;
    assign if_valid    = r_valid;
    assign fetch_fault = r_fault;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_pc_out   <= '0;
            r_ir       <= NOP_INSTR;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
            r_tcnt     <= '0;
            r_sk_pc    <= '0;
            r_sk_ir    <= NOP_INSTR;
        end else if (r_state == ST_FAULT) begin
            r_tcnt <= '0;
        end else if (w_timeout) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
            r_ir    <= NOP_INSTR;
            r_valid <= 1'b0;
            r_tcnt  <= '0;
        end else begin
            r_tcnt <= w_wait ? r_tcnt + TW'(1) : '0;
            if (redirect_en) begin
                // an unacked request must still complete at its old address before refetching
                r_pc       <= redirect_pc;
                r_pc_out   <= '0;
                r_ir       <= NOP_INSTR;
                r_valid    <= 1'b0;
                r_sk_pc    <= '0;
                r_sk_ir    <= NOP_INSTR;
                r_state    <= w_wait ? ST_DROP : ST_FETCH;
                r_req_addr <= w_wait ? r_req_addr : redirect_pc;
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        if (w_ack) begin
                            r_pc       <= r_pc + PC_W'(1);
                            r_req_addr <= r_pc + PC_W'(1);
                            if (stall) begin
                                r_sk_pc <= r_req_addr;
                                r_sk_ir <= imem.imem_rdata;
                                r_state <= ST_HOLD;
                            end else begin
                                r_pc_out <= r_req_addr;
                                r_ir     <= imem.imem_rdata;
                                r_valid  <= 1'b1;
                            end
                        end else if (!stall) begin
                            r_pc_out <= r_req_addr;
                            r_ir     <= NOP_INSTR;
                            r_valid  <= 1'b0;
                        end
                    end
                    ST_HOLD: begin
                        if (!stall) begin
                            r_pc_out <= r_sk_pc;
                            r_ir     <= r_sk_ir;
                            r_valid  <= 1'b1;
                            r_state  <= ST_FETCH;
                        end
                    end
                    ST_DROP: begin
                        if (w_ack) begin
                            r_req_addr <= r_pc;
                            r_state    <= ST_FETCH;
                        end
                    end
                    default: r_state <= ST_FAULT;
                endcase
            end
        end
    end
endmodule
